key_conditioner: RTL and testbench

Multi-channel push-button conditioner between the board's raw player buttons and the game control logic, alongside the reset filter. Each channel is synchronised into `clk`, debounced with a stability counter, and reduced to a clean level plus one-cycle press/release events. Each channel also raises a long-press flag and an auto-repeat pulse train so swing and menu logic can consume a uniform event stream.

---
 rtl/key_conditioner.sv | 129 ++++++++++++
 tb/tb_key_conditioner.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// Multi-channel push-button conditioner: two-flop synchroniser, stability-count
// debounce, press/release events, long-press hold flag and auto-repeat pulses.
module key_conditioner #(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 1000000,
    parameter int REPEAT_CYCLES   = 200000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] key_raw,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_hold,
    output logic [N_KEYS-1:0] key_repeat
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int REP_W  = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RELEASED,
        ST_PRESSED,
        ST_HELD
    } key_state_e;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        logic              s1, s2;
        logic [DB_W-1:0]   db_cnt;
        logic [HOLD_W-1:0] hold_cnt;
        logic [REP_W-1:0]  rep_cnt;
        key_state_e        state;
        logic              level, press, rel, hold, rpt;
        logic              flip;

        // The level flips on the last cycle of a full-length mismatch run.
        assign flip = (s2 != level) && (db_cnt == DB_LAST);

        // NOTE: every clocked block uses non-blocking assignments so all flops
        // sample pre-edge values; blocking here would collapse the two sync stages.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1 <= 1'b0;
                s2 <= 1'b0;
            end else begin
                s1 <= key_raw[i];
                s2 <= s1;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                db_cnt <= '0;
                level  <= 1'b0;
                press  <= 1'b0;
                rel    <= 1'b0;
            end else begin
                press <= 1'b0;
                rel   <= 1'b0;
                if (s2 == level) begin
                    db_cnt <= '0;
                end else if (flip) begin
                    db_cnt <= '0;
                    level  <= ~level;
                    press  <= ~level;
                    rel    <= level;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end
        end

        // Edges share the flip condition so the hold/repeat state moves in the
        // same cycle the new level becomes visible.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state    <= ST_RELEASED;
                hold_cnt <= '0;
                rep_cnt  <= '0;
                hold     <= 1'b0;
                rpt      <= 1'b0;
            end else begin
                rpt <= 1'b0;
                if (flip) begin
                    state    <= level ? ST_RELEASED : ST_PRESSED;
                    hold_cnt <= '0;
                    rep_cnt  <= '0;
                    hold     <= 1'b0;
                end else begin
                    case (state)
                        ST_PRESSED: begin
                            if (hold_cnt == HOLD_LAST) begin
                                hold_cnt <= HOLD_MAX;
                                hold     <= 1'b1;
                                rpt      <= 1'b1;
                                state    <= ST_HELD;
                            end else begin
                                hold_cnt <= hold_cnt + 1'b1;
                            end
                        end
                        ST_HELD: begin
                            if (rep_cnt == REP_LAST) begin
                                rep_cnt <= '0;
                                rpt     <= 1'b1;
                            end else begin
                                rep_cnt <= rep_cnt + 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end

        assign key_level[i]   = level;
        assign key_press[i]   = press;
        assign key_release[i] = rel;
        assign key_hold[i]    = hold;
        assign key_repeat[i]  = rpt;
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with N_KEYS=2, DEBOUNCE=4, HOLD=8, REPEAT=3.
module tb_key_conditioner;

    logic       clk;
    logic       rst_n;
    logic [1:0] key_raw;
    logic [1:0] key_level, key_press, key_release, key_hold, key_repeat;

    int errors = 0;
    int checks = 0;

    key_conditioner #(
        .N_KEYS(2),
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES(8),
        .REPEAT_CYCLES(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .key_raw(key_raw),
        .key_level(key_level),
        .key_press(key_press),
        .key_release(key_release),
        .key_hold(key_hold),
        .key_repeat(key_repeat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Observed bundle order: {level, press, release, hold, repeat}, 2 bits each.
    function automatic logic [31:0] pack(input logic [1:0] lv, pr, rl, hd, rp);
        return {22'd0, lv, pr, rl, hd, rp};
    endfunction

    function automatic logic [31:0] obs();
        return pack(key_level, key_press, key_release, key_hold, key_repeat);
    endfunction

    logic [1:0] lv, pr, rl, hd, rp;

    initial begin
        rst_n   = 1'b0;
        key_raw = 2'b11;

        // Reset with both keys held, then fresh press on both channels.
        repeat (3) step();
        check("reset_outputs", obs(), pack(0, 0, 0, 0, 0));
        rst_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            step();
            lv = (e >= 6) ? 2'b11 : 2'b00;
            pr = (e == 6) ? 2'b11 : 2'b00;
            check($sformatf("post_reset_e%0d", e), obs(), pack(lv, pr, 0, 0, 0));
        end
        key_raw = 2'b00;
        repeat (12) step();
        check("post_reset_idle", obs(), pack(0, 0, 0, 0, 0));

        // Clean press on ch0 held 25 cycles, then release while held.
        key_raw = 2'b01;
        for (int e = 1; e <= 25; e++) begin
            step();
            lv = {1'b0, e >= 6};
            pr = {1'b0, e == 6};
            hd = {1'b0, e >= 14};
            rp = {1'b0, (e == 14) || (e == 17) || (e == 20) || (e == 23)};
            check($sformatf("press_e%0d", e), obs(), pack(lv, pr, 0, hd, rp));
        end
        key_raw = 2'b00;
        for (int r = 1; r <= 9; r++) begin
            step();
            lv = {1'b0, r < 6};
            rl = {1'b0, r == 6};
            hd = {1'b0, r < 6};
            rp = {1'b0, (r == 1) || (r == 4)};
            check($sformatf("release_r%0d", r), obs(), pack(lv, 0, rl, hd, rp));
        end

        // Three-cycle glitch is rejected.
        key_raw = 2'b01;
        for (int e = 1; e <= 14; e++) begin
            step();
            check($sformatf("glitch_e%0d", e), obs(), pack(0, 0, 0, 0, 0));
            if (e == 3) key_raw = 2'b00;
        end

        // Bounce every 2 cycles for 12 cycles, then steady high from edge 13.
        for (int e = 1; e <= 19; e++) begin
            key_raw = {1'b0, (e >= 13) || (((e - 1) / 2) % 2 == 0)};
            step();
            lv = {1'b0, e >= 18};
            pr = {1'b0, e == 18};
            check($sformatf("bounce_e%0d", e), obs(), pack(lv, pr, 0, 0, 0));
        end
        key_raw = 2'b00;
        repeat (10) step();
        check("bounce_idle", obs(), pack(0, 0, 0, 0, 0));

        // Ch1 pressed two cycles after ch0; async reset mid-hold.
        for (int e = 1; e <= 15; e++) begin
            key_raw = {e >= 3, 1'b1};
            step();
            lv = {e >= 8, e >= 6};
            pr = {e == 8, e == 6};
            hd = {1'b0, e >= 14};
            rp = {1'b0, e == 14};
            check($sformatf("indep_e%0d", e), obs(), pack(lv, pr, 0, hd, rp));
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_clear", obs(), pack(0, 0, 0, 0, 0));
        #1;
        rst_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            step();
            lv = (e >= 6) ? 2'b11 : 2'b00;
            pr = (e == 6) ? 2'b11 : 2'b00;
            check($sformatf("repress_e%0d", e), obs(), pack(lv, pr, 0, 0, 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
